// File: rtl/ram_pkg.sv
// Shared encodings and request layout for the ram_controller command path.
package ram_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_ISSUE   = 2'd1,
    SEQ_RELEASE = 2'd2
  } seq_state_e;

  // Default-width view of a queued request; FIFO words use the same order.
  typedef struct packed {
    logic                  rw;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_req_fifo.sv
// Parameterised synchronous FIFO with occupancy count.
// DEPTH must be a power of two so pointers wrap naturally.
module ram_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ram_req_sequencer.sv
// Queues read/write requests and issues them one at a time to
// ram_controller, returning one in-order response per request.
module ram_req_sequencer
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_rw,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ctrl_start,
  output logic                  ctrl_rw,
  output logic [ADDR_WIDTH-1:0] ctrl_address,
  output logic [DATA_WIDTH-1:0] ctrl_write_data,
  input  logic [DATA_WIDTH-1:0] ctrl_read_data,
  input  logic                  ctrl_done,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  busy
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  seq_state_e state_q, state_d;

  logic [REQ_W-1:0]      fifo_wdata;
  logic [REQ_W-1:0]      fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  avail_q;

  logic                  head_rw;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  logic                  start_q, start_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_rw_q, rsp_rw_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slot_free;

  assign fifo_wdata = {req_rw, req_addr, req_wdata};
  assign head_rw    = fifo_head[REQ_W-1];
  assign head_addr  = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_wdata = fifo_head[DATA_WIDTH-1:0];

  ram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign req_ready = !fifo_full;
  assign slot_free = !rsp_valid_q || rsp_ready;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rw_d    = rsp_rw_q;
    rdata_d     = rdata_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        start_d = 1'b0;
        // avail_q gives the head one settle cycle after it lands
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          rw_d     = head_rw;
          addr_d   = head_addr;
          wdata_d  = head_wdata;
          start_d  = 1'b1;
          state_d  = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (ctrl_done && slot_free) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = rw_q;
          rdata_d     = (rw_q == RW_READ) ? ctrl_read_data : '0;
          start_d     = 1'b0;
          state_d     = SEQ_RELEASE;
        end
      end
      SEQ_RELEASE: begin
        start_d = 1'b0;
        if (!ctrl_done) state_d = SEQ_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      avail_q     <= 1'b0;
      start_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      avail_q     <= !fifo_empty;
      start_q     <= start_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ctrl_start      = start_q;
  assign ctrl_rw         = rw_q;
  assign ctrl_address    = addr_q;
  assign ctrl_write_data = wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rw          = rsp_rw_q;
  assign rsp_rdata       = rdata_q;
  assign busy            = (state_q != SEQ_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Scoreboard bench for ram_req_sequencer with a behavioural
// ram_controller model (start/done level handshake).
module tb_ram_req_sequencer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_rw;
  logic [DW-1:0] rsp_rdata;
  logic          ctrl_start;
  logic          ctrl_rw;
  logic [AW-1:0] ctrl_address;
  logic [DW-1:0] ctrl_write_data;
  logic [DW-1:0] ctrl_read_data;
  logic          ctrl_done;
  logic [LW-1:0] fifo_level;
  logic          busy;

  ram_req_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rw          (rsp_rw),
    .rsp_rdata       (rsp_rdata),
    .ctrl_start      (ctrl_start),
    .ctrl_rw         (ctrl_rw),
    .ctrl_address    (ctrl_address),
    .ctrl_write_data (ctrl_write_data),
    .ctrl_read_data  (ctrl_read_data),
    .ctrl_done       (ctrl_done),
    .fifo_level      (fifo_level),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          rw;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t          exp_rsp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  rsp_t          mon_e;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ram_controller model: IDLE -> BUSY(lat) -> DONE, done held until start drops
  typedef enum {C_IDLE, C_BUSY, C_DONE} cst_e;
  cst_e          cst;
  int            cnt;
  int            lat = 2;
  logic          ram_ready = 1'b1;
  logic [DW-1:0] mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cst            <= C_IDLE;
      cnt            <= 0;
      ctrl_done      <= 1'b0;
      ctrl_read_data <= '0;
    end else begin
      case (cst)
        C_IDLE: if (ctrl_start) begin
          cnt <= lat;
          cst <= C_BUSY;
        end
        C_BUSY: if (ram_ready) begin
          if (cnt == 0) begin
            if (ctrl_rw) mem[ctrl_address] <= ctrl_write_data;
            else ctrl_read_data <= mem[ctrl_address];
            ctrl_done <= 1'b1;
            cst       <= C_DONE;
          end else begin
            cnt <= cnt - 1;
          end
        end
        C_DONE: if (!ctrl_start) begin
          ctrl_done <= 1'b0;
          cst       <= C_IDLE;
        end
        default: cst <= C_IDLE;
      endcase
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rw=%0b rdata=%0h, none expected",
                 rsp_rw, rsp_rdata);
      end else begin
        mon_e = exp_rsp_q.pop_front();
        chk("rsp_rw", rsp_rw, mon_e.rw);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  // issue monitor: address order and no start while done is high
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst && ctrl_start && !prev_start) begin
      chk("start_while_done", ctrl_done, 0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got addr %0h, none expected",
                 ctrl_address);
      end else begin
        chk("issue_addr", ctrl_address, exp_addr_q.pop_front());
      end
    end
    prev_start = ctrl_start;
  end

  task automatic send(input logic rw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    int n = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 400);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready got 0 required 1 addr %0h", a);
    end else begin
      exp_rsp_q.push_back({rw, exp_rd});
      exp_addr_q.push_back(a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || busy || rsp_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic t3_done = 1'b0;
  logic t6_done = 1'b0;
  logic t6_go   = 1'b0;

  initial begin
    int n;
    int seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rw", rsp_rw, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ctrl_start", ctrl_start, 0);
    chk("rst_ctrl_rw", ctrl_rw, 0);
    chk("rst_ctrl_address", ctrl_address, 0);
    chk("rst_ctrl_wdata", ctrl_write_data, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single write, latency and release
    lat = 2;
    send(1'b1, 8'h10, 8'hA5, 8'h00);
    @(negedge clk);
    chk("t1_start_n0", ctrl_start, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_start_n1", ctrl_start, 0);
    @(negedge clk);
    chk("t1_start_n2", ctrl_start, 1);
    chk("t1_wdata", ctrl_write_data, 8'hA5);
    chk("t1_rw", ctrl_rw, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_rsp_seen", rsp_valid, 1);
    chk("t1_release_start", ctrl_start, 0);
    chk("t1_release_done", ctrl_done, 1);
    drain("t1_drain");

    // write then read back
    send(1'b1, 8'h22, 8'h3C, 8'h00);
    send(1'b0, 8'h22, 8'h00, 8'h3C);
    drain("t2_drain");

    // stalled controller fills the FIFO
    ram_ready = 1'b0;
    fork
      begin
        send(1'b1, 8'h30, 8'h11, 8'h00);
        send(1'b1, 8'h31, 8'h22, 8'h00);
        send(1'b1, 8'h32, 8'h33, 8'h00);
        send(1'b0, 8'h31, 8'h00, 8'h22);
        send(1'b1, 8'h33, 8'h44, 8'h00);
        send(1'b0, 8'h30, 8'h00, 8'h11);
        t3_done = 1'b1;
      end
    join_none
    repeat (15) @(negedge clk);
    chk("t3_level_full", fifo_level, 4);
    chk("t3_req_ready", req_ready, 0);
    chk("t3_sixth_pending", req_valid, 1);
    chk("t3_busy", busy, 1);
    @(posedge clk);
    #1;
    ram_ready = 1'b1;
    n = 0;
    while (!t3_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t3_sends_done", t3_done, 1);
    drain("t3_drain");

    // back-pressured response slot
    rsp_ready = 1'b0;
    send(1'b0, 8'h30, 8'h00, 8'h11);
    send(1'b0, 8'h32, 8'h00, 8'h33);
    n = 0;
    while (!(rsp_valid && ctrl_start && ctrl_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_parked_valid", rsp_valid, 1);
    chk("t4_parked_start", ctrl_start, 1);
    chk("t4_parked_addr", ctrl_address, 8'h32);
    chk("t4_first_data", rsp_rdata, 8'h11);
    repeat (3) @(negedge clk);
    chk("t4_hold_start", ctrl_start, 1);
    chk("t4_hold_data", rsp_rdata, 8'h11);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t4_swap_valid", rsp_valid, 1);
    chk("t4_swap_data", rsp_rdata, 8'h33);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain("t4_drain");

    // reset while a request is in ISSUE and three are queued
    ram_ready = 1'b0;
    send(1'b1, 8'h50, 8'h01, 8'h00);
    send(1'b1, 8'h51, 8'h02, 8'h00);
    send(1'b1, 8'h52, 8'h03, 8'h00);
    send(1'b1, 8'h53, 8'h04, 8'h00);
    n = 0;
    while (!(fifo_level == 3 && ctrl_start) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_pre_level", fifo_level, 3);
    chk("t5_pre_start", ctrl_start, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ctrl_start", ctrl_start, 0);
    chk("t5_fifo_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_ctrl_address", ctrl_address, 0);
    chk("t5_ctrl_wdata", ctrl_write_data, 0);
    exp_rsp_q.delete();
    exp_addr_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ram_ready = 1'b1;
    seen      = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || ctrl_start) seen++;
    end
    chk("t5_no_activity", seen, 0);
    @(posedge clk);
    #1;

    // fill, then stream through the wrap point with varying gaps
    lat       = 0;
    ram_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(1'b1, 8'(8'h60 + i), 8'(i), 8'h00);
        while (!t6_go) begin
          @(posedge clk);
          #1;
        end
        for (int i = 5; i < 17; i++) begin
          send(1'b1, 8'(8'h60 + i), 8'(i), 8'h00);
          repeat (i % 5) @(posedge clk);
          #1;
        end
        t6_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    chk("t6_level_full", fifo_level, 4);
    chk("t6_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    ram_ready = 1'b1;
    t6_go     = 1'b1;
    n = 0;
    while (!t6_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_sends_done", t6_done, 1);
    drain("t6_drain");
    chk("t6_addr_q_empty", exp_addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
